// File: rtl/mant_div_seq_if.sv
// Purpose : request/result bundle between the unpack stage and the
//           iterative significand divider.
// Signals : start/dividend/divisor flow toward the divider;
//           busy/done/quotient/remainder/sticky/div_zero flow back.
// Modports: master = requester (unpack stage / bench), slave = divider.
interface mant_div_seq_if;
  localparam int unsigned SIG_W = 24;
  localparam int unsigned QUO_W = 26;

  logic             start;
  logic [SIG_W-1:0] dividend;
  logic [SIG_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [QUO_W-1:0] quotient;
  logic [SIG_W-1:0] remainder;
  logic             sticky;
  logic             div_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  sticky,
    input  div_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output sticky,
    output div_zero
  );
endinterface

// File: rtl/mant_div_seq.sv
// Purpose : restoring divider for binary32 significands. Retires one
//           quotient bit per cycle: quotient = floor(A*2^25 / B),
//           remainder = A*2^25 - quotient*B, sticky = (remainder != 0).
//           A zero divisor short-circuits to an all-ones quotient.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - mant_div_seq_if.slave (request inputs, result outputs)
// All outputs are registers; nothing from the inputs reaches an output
// combinationally.
module mant_div_seq (
  input  logic           clk,
  input  logic           rst,
  mant_div_seq_if.slave  bus
);

  localparam int unsigned SIG_W = 24;
  localparam int unsigned QUO_W = 26;
  localparam int unsigned P_W   = SIG_W + 1;   // partial remainder < 2*B
  localparam int unsigned D_W   = SIG_W + 2;   // sum width, MSB = borrow
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(QUO_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic [P_W-1:0]     p_q,      p_d;
  logic [D_W-1:0]     nb_q,     nb_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [QUO_W-1:0]   quot_q,   quot_d;
  logic [SIG_W-1:0]   rem_q,    rem_d;
  logic               sticky_q, sticky_d;
  logic               dz_q,     dz_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  // Shared subtract path: P + (-B). A clear MSB means P >= B.
  logic [D_W-1:0]     diff_c;
  logic               ge_c;
  logic [P_W-1:0]     p_sel_c;

  always_comb begin
    diff_c  = {1'b0, p_q} + nb_q;
    ge_c    = ~diff_c[D_W-1];
    p_sel_c = ge_c ? diff_c[P_W-1:0] : p_q;
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      nb_q     <= '0;
      count_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      nb_q     <= nb_d;
      count_q  <= count_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    nb_d     = nb_q;
    count_d  = count_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;
    dz_d     = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            p_d     = {1'b0, bus.dividend};
            // Negate once here so every iteration is a plain add.
            nb_d    = (~{2'b00, bus.divisor}) + D_W'(1);
            count_d = LAST_BIT;
            quot_d  = '0;
            dz_d    = 1'b0;
            state_d = S_RUN;
          end else begin
            quot_d   = '1;
            rem_d    = '0;
            sticky_d = 1'b1;
            dz_d     = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_RUN: begin
        quot_d[count_q] = ge_c;
        if (count_q != '0) begin
          p_d     = {p_sel_c[P_W-2:0], 1'b0};
          count_d = count_q - CNT_W'(1);
        end else begin
          // Final restored remainder is < B, so it fits in SIG_W bits.
          rem_d    = p_sel_c[SIG_W-1:0];
          sticky_d = |p_sel_c;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags follow the state being entered, so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.sticky    = sticky_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Bench for mant_div_seq: an arithmetic reference model tracks expected
// busy/done timing and results; a per-cycle compare process checks the DUT
// against it, and directed runs pin literal values and latencies.
module tb_mant_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mant_div_seq_if dif ();

  mant_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] f_num(input logic [23:0] a);
    f_num = {40'd0, a} << 25;
  endfunction

  function automatic logic [63:0] f_quot(input logic [23:0] a, input logic [23:0] b);
    f_quot = f_num(a) / {40'd0, b};
  endfunction

  function automatic logic [63:0] f_rem(input logic [23:0] a, input logic [23:0] b);
    f_rem = f_num(a) - f_quot(a, b) * {40'd0, b};
  endfunction

  // Reference model: accepted request -> results and the cycle done appears.
  logic        m_init = 1'b0;
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [25:0] m_q    = '0;
  logic [23:0] m_r    = '0;
  logic        m_s    = 1'b0;
  logic        m_z    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      m_busy <= 1'b0;
      m_left <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_s    <= 1'b0;
      m_z    <= 1'b0;
    end else if (!m_busy) begin
      if (dif.start) begin
        m_busy <= 1'b1;
        if (dif.divisor == 24'd0) begin
          m_left <= 0;
          m_q    <= 26'h3FFFFFF;
          m_r    <= '0;
          m_s    <= 1'b1;
          m_z    <= 1'b1;
        end else begin
          m_left <= 26;
          m_q    <= 26'(f_quot(dif.dividend, dif.divisor));
          m_r    <= 24'(f_rem(dif.dividend, dif.divisor));
          m_s    <= (f_rem(dif.dividend, dif.divisor) != 64'd0);
          m_z    <= 1'b0;
        end
      end
    end else if (m_left == 0) begin
      m_busy <= 1'b0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  // Per-cycle comparison; results are meaningful whenever not mid-division.
  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", 64'(dif.busy), 64'(m_busy));
      chk("done", 64'(dif.done), 64'(m_busy && m_left == 0));
      if (!m_busy || m_left == 0) begin
        chk("quotient",  64'(dif.quotient),  64'(m_q));
        chk("remainder", 64'(dif.remainder), 64'(m_r));
        chk("sticky",    64'(dif.sticky),    64'(m_s));
        chk("div_zero",  64'(dif.div_zero),  64'(m_z));
      end
    end
  end

  // One division; checks latency, literal results when lit=1, and idle after.
  task automatic run_div(input string nm, input logic [23:0] a, input logic [23:0] b,
                         input bit hold, input bit lit, input logic [25:0] eq,
                         input logic [23:0] er, input bit es, input bit ez);
    int  n;
    bit  seen;
    int  busy_cyc;
    n = 0;
    seen = 1'b0;
    busy_cyc = 0;
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!hold) dif.start = 1'b0;
      dif.dividend = 24'($urandom);
      dif.divisor  = 24'($urandom);
      if (dif.busy) busy_cyc++;
      if (dif.done) seen = 1'b1;
    end
    chk({nm, "_latency"}, 64'(n), (b == 24'd0) ? 64'd1 : 64'd27);
    chk({nm, "_busy_cycles"}, 64'(busy_cyc), (b == 24'd0) ? 64'd1 : 64'd27);
    if (lit) begin
      chk({nm, "_q"},  64'(dif.quotient),  64'(eq));
      chk({nm, "_r"},  64'(dif.remainder), 64'(er));
      chk({nm, "_s"},  64'(dif.sticky),    64'(es));
      chk({nm, "_dz"}, 64'(dif.div_zero),  64'(ez));
    end
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk({nm, "_idle_busy"}, 64'(dif.busy), 64'd0);
    chk({nm, "_idle_done"}, 64'(dif.done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_hold_busy"}, 64'(dif.busy), 64'd0);
    if (lit) chk({nm, "_hold_q"}, 64'(dif.quotient), 64'(eq));
  endtask

  initial begin
    int dones;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_quotient", 64'(dif.quotient),  64'd0);
    chk("rst_busy",     64'(dif.busy),      64'd0);
    chk("rst_done",     64'(dif.done),      64'd0);
    chk("rst_sticky",   64'(dif.sticky),    64'd0);
    chk("rst_div_zero", 64'(dif.div_zero),  64'd0);

    run_div("one",   24'h800000, 24'h800000, 1'b0, 1'b1, 26'h2000000, 24'h000000, 1'b0, 1'b0);
    run_div("c_8",   24'hC00000, 24'h800000, 1'b0, 1'b1, 26'h3000000, 24'h000000, 1'b0, 1'b0);
    run_div("8_c",   24'h800000, 24'hC00000, 1'b0, 1'b1, 26'h1555555, 24'h400000, 1'b1, 1'b0);
    run_div("max",   24'hFFFFFF, 24'h800000, 1'b0, 1'b1, 26'h3FFFFFC, 24'h000000, 1'b0, 1'b0);
    run_div("f_c",   24'hFFFFFF, 24'hC00000, 1'b0, 1'b1, 26'h2AAAAA8, 24'h000000, 1'b0, 1'b0);
    run_div("zero",  24'h123456, 24'h000000, 1'b0, 1'b1, 26'h3FFFFFF, 24'h000000, 1'b1, 1'b1);
    run_div("after_zero", 24'h800000, 24'hC00000, 1'b0, 1'b1, 26'h1555555, 24'h400000, 1'b1, 1'b0);
    run_div("hold",  24'hC00000, 24'h800000, 1'b1, 1'b1, 26'h3000000, 24'h000000, 1'b0, 1'b0);
    run_div("mix1",  24'hABCDEF, 24'h912345, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_div("mix2",  24'h800001, 24'hFFFFFF, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    run_div("mix3",  24'hFFFFFF, 24'h800001, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Reset during RUN cycle 10 discards the division.
    @(negedge clk);
    dif.dividend = 24'hFFFFFF;
    dif.divisor  = 24'hC00000;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_run_busy", 64'(dif.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_run_busy", 64'(dif.busy), 64'd0);
    chk("rst_run_done", 64'(dif.done), 64'd0);
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (dif.done) dones++;
    end
    chk("rst_run_no_done", 64'(dones), 64'd0);

    run_div("post_rst", 24'h800000, 24'hC00000, 1'b0, 1'b1, 26'h1555555, 24'h400000, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
